// File: rtl/laser_point_feeder.sv
// -----------------------------------------------------------------------------
// laser_point_feeder
//   Transmit-side partner of the LASER circle-placement engine. Holds a
//   target-point pattern, streams it one point per cycle on X/Y, waits for the
//   engine's DONE strobe, captures the two returned circle centres and scores
//   them by counting buffered points that either circle covers.
//
//   Optional feature macro: LASER_FEED_SCORE_EN
//     defined     : SCORE state and the coverage datapath are built.
//     not defined : WAIT reports straight after DONE, o_res_cover stays 0 and
//                   no multipliers are built.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_wr_en/i_wr_addr/i_wr_x/i_wr_y  pattern buffer write port (IDLE only)
//   i_start                 frame start pulse, honoured only in IDLE
//   o_busy                  high in every state except IDLE
//   o_x, o_y                point stream to LASER, 0 outside STREAM
//   i_done, i_c1x..i_c2y    LASER result strobe and circle centres
//   o_res_valid             one-cycle result pulse
//   o_res_c1x..o_res_c2y    captured centres, held until next capture
//   o_res_cover             covered-point count
//   o_res_timeout           frame aborted while waiting for DONE
// -----------------------------------------------------------------------------
module laser_point_feeder #(
  parameter int NPTS    = 40,
  parameter int RADSQ   = 16,
  parameter int TIMEOUT = 4095
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wr_en,
  input  logic [5:0] i_wr_addr,
  input  logic [3:0] i_wr_x,
  input  logic [3:0] i_wr_y,
  input  logic       i_start,
  output logic       o_busy,
  output logic [3:0] o_x,
  output logic [3:0] o_y,
  input  logic       i_done,
  input  logic [3:0] i_c1x,
  input  logic [3:0] i_c1y,
  input  logic [3:0] i_c2x,
  input  logic [3:0] i_c2y,
  output logic       o_res_valid,
  output logic [3:0] o_res_c1x,
  output logic [3:0] o_res_c1y,
  output logic [3:0] o_res_c2x,
  output logic [3:0] o_res_c2y,
  output logic [5:0] o_res_cover,
  output logic       o_res_timeout
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STREAM = 3'd1,
    S_WAIT   = 3'd2,
    S_SCORE  = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  localparam logic [5:0]  LAST_IDX   = 6'(NPTS - 1);
  localparam logic [11:0] WAIT_LIMIT = 12'(TIMEOUT);

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_buf [NPTS];
  logic [5:0]  r_idx;
  logic [11:0] r_wcnt;
  logic [3:0]  r_x, r_y;
  logic        r_busy;
  logic        r_res_valid;
  logic        r_res_timeout;
  logic [3:0]  r_res_c1x, r_res_c1y, r_res_c2x, r_res_c2y;
  logic [5:0]  r_res_cover;

  logic        w_wr_take;
  logic [5:0]  w_idx_inc;
  logic [7:0]  w_pt0;
  logic [7:0]  w_pt_next;
  logic        w_idx_last;

  assign w_wr_take  = i_wr_en && (r_state == S_IDLE) && (i_wr_addr < 6'(NPTS));
  assign w_idx_inc  = r_idx + 6'd1;
  assign w_idx_last = (r_idx == LAST_IDX);
  // A write to entry 0 in the start cycle lands in the buffer on the same
  // edge that loads point 0, so forward it to keep the stream coherent.
  assign w_pt0      = (i_wr_en && (i_wr_addr == 6'd0)) ? {i_wr_x, i_wr_y} : r_buf[0];
  assign w_pt_next  = r_buf[w_idx_inc];

`ifdef LASER_FEED_SCORE_EN
  // Squared distance between a point and a centre; fits in 9 bits (max 450).
  function automatic logic [8:0] dist_sq(input logic [3:0] ax, input logic [3:0] ay,
                                         input logic [3:0] bx, input logic [3:0] by);
    logic signed [4:0] dx, dy;
    logic signed [9:0] ex, ey, sx, sy;
    dx = $signed({1'b0, ax}) - $signed({1'b0, bx});
    dy = $signed({1'b0, ay}) - $signed({1'b0, by});
    ex = 10'(dx);
    ey = 10'(dy);
    sx = ex * ex;
    sy = ey * ey;
    dist_sq = sx[8:0] + sy[8:0];
  endfunction

  logic [7:0] w_pt_score;
  logic [8:0] w_d1, w_d2;
  logic       w_cov;
  assign w_pt_score = r_buf[r_idx];
  assign w_d1  = dist_sq(w_pt_score[7:4], w_pt_score[3:0], r_res_c1x, r_res_c1y);
  assign w_d2  = dist_sq(w_pt_score[7:4], w_pt_score[3:0], r_res_c2x, r_res_c2y);
  assign w_cov = (w_d1 <= 9'(RADSQ)) || (w_d2 <= 9'(RADSQ));
`else
  logic [8:0] w_unused_radsq;
  assign w_unused_radsq = 9'(RADSQ);
`endif

  // Pattern buffer: loaded only while idle and deliberately never reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_take) begin
      r_buf[i_wr_addr] <= {i_wr_x, i_wr_y};
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next_state = S_STREAM;
        else         w_next_state = S_IDLE;
      end
      S_STREAM: begin
        if (w_idx_last) w_next_state = S_WAIT;
        else            w_next_state = S_STREAM;
      end
      S_WAIT: begin
        // DONE takes priority over the timeout limit on the same cycle.
`ifdef LASER_FEED_SCORE_EN
        if (i_done)                        w_next_state = S_SCORE;
`else
        if (i_done)                        w_next_state = S_REPORT;
`endif
        else if (r_wcnt == WAIT_LIMIT)     w_next_state = S_REPORT;
        else                               w_next_state = S_WAIT;
      end
      S_SCORE: begin
        if (w_idx_last) w_next_state = S_REPORT;
        else            w_next_state = S_SCORE;
      end
      S_REPORT: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Datapath: stream output, wait counter, result capture and scoring.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx         <= 6'd0;
      r_wcnt        <= 12'd0;
      r_x           <= 4'd0;
      r_y           <= 4'd0;
      r_busy        <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_timeout <= 1'b0;
      r_res_c1x     <= 4'd0;
      r_res_c1y     <= 4'd0;
      r_res_c2x     <= 4'd0;
      r_res_c2y     <= 4'd0;
      r_res_cover   <= 6'd0;
    end else begin
      r_res_valid <= 1'b0;
      r_busy      <= (w_next_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_idx <= 6'd0;
            r_x   <= w_pt0[7:4];
            r_y   <= w_pt0[3:0];
          end else begin
            r_x <= 4'd0;
            r_y <= 4'd0;
          end
        end
        S_STREAM: begin
          if (w_idx_last) begin
            r_x    <= 4'd0;
            r_y    <= 4'd0;
            r_wcnt <= 12'd0;
          end else begin
            r_idx <= w_idx_inc;
            r_x   <= w_pt_next[7:4];
            r_y   <= w_pt_next[3:0];
          end
        end
        S_WAIT: begin
          r_wcnt <= r_wcnt + 12'd1;
          if (i_done) begin
            r_res_c1x     <= i_c1x;
            r_res_c1y     <= i_c1y;
            r_res_c2x     <= i_c2x;
            r_res_c2y     <= i_c2y;
            r_res_timeout <= 1'b0;
            r_res_cover   <= 6'd0;
            r_idx         <= 6'd0;
`ifndef LASER_FEED_SCORE_EN
            r_res_valid   <= 1'b1;
`endif
          end else if (r_wcnt == WAIT_LIMIT) begin
            r_res_timeout <= 1'b1;
            r_res_cover   <= 6'd0;
            r_res_valid   <= 1'b1;
          end
        end
        S_SCORE: begin
`ifdef LASER_FEED_SCORE_EN
          r_res_cover <= r_res_cover + {5'd0, w_cov};
          r_idx       <= w_idx_inc;
          if (w_idx_last) r_res_valid <= 1'b1;
`endif
        end
        S_REPORT: begin
          r_x <= 4'd0;
          r_y <= 4'd0;
        end
        default: begin
          r_x <= 4'd0;
          r_y <= 4'd0;
        end
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_res_valid   = r_res_valid;
  assign o_res_timeout = r_res_timeout;
  assign o_res_c1x     = r_res_c1x;
  assign o_res_c1y     = r_res_c1y;
  assign o_res_c2x     = r_res_c2x;
  assign o_res_c2y     = r_res_c2y;
  assign o_res_cover   = r_res_cover;

endmodule

// File: tb/tb_laser_point_feeder.sv
// -----------------------------------------------------------------------------
// tb_laser_point_feeder
//   Self-checking bench for laser_point_feeder. A behavioural model (point
//   arrays plus plain-arithmetic coverage count) predicts the stream, result
//   latency and results; directed frames are followed by randomized ones.
// -----------------------------------------------------------------------------
module tb_laser_point_feeder;
  localparam int NPTS    = 40;
  localparam int RADSQ   = 16;
  localparam int TIMEOUT = 4095;

  logic       clk = 1'b0;
  logic       rst, wr_en, start, done;
  logic [5:0] wr_addr;
  logic [3:0] wr_x, wr_y, c1x, c1y, c2x, c2y;
  logic       busy, res_valid, res_timeout;
  logic [3:0] x, y, r1x, r1y, r2x, r2y;
  logic [5:0] res_cover;

  int n_total = 0;
  int n_bad   = 0;

  int mx [NPTS];
  int my [NPTS];
  int m_c1x = 0, m_c1y = 0, m_c2x = 0, m_c2y = 0, m_cover = 0, m_timeout = 0;

  laser_point_feeder #(.NPTS(NPTS), .RADSQ(RADSQ), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_x(wr_x), .i_wr_y(wr_y), .i_start(start), .o_busy(busy),
    .o_x(x), .o_y(y), .i_done(done), .i_c1x(c1x), .i_c1y(c1y),
    .i_c2x(c2x), .i_c2y(c2y), .o_res_valid(res_valid),
    .o_res_c1x(r1x), .o_res_c1y(r1y), .o_res_c2x(r2x), .o_res_c2y(r2y),
    .o_res_cover(res_cover), .o_res_timeout(res_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int model_cover(input int ax, input int ay, input int bx, input int by);
    int c = 0;
    for (int i = 0; i < NPTS; i++) begin
      int d1 = (mx[i] - ax) * (mx[i] - ax) + (my[i] - ay) * (my[i] - ay);
      int d2 = (mx[i] - bx) * (mx[i] - bx) + (my[i] - by) * (my[i] - by);
      if (d1 <= RADSQ || d2 <= RADSQ) c++;
    end
    return c;
  endfunction

  task automatic load_pt(input int a, input int px, input int py);
    wr_en = 1'b1; wr_addr = 6'(a); wr_x = 4'(px); wr_y = 4'(py);
    if (a < NPTS) begin mx[a] = px; my[a] = py; end
    tick();
    wr_en = 1'b0;
  endtask

  task automatic check_results(input string tag);
    check_val({tag, "_c1x"}, int'(r1x), m_c1x);
    check_val({tag, "_c1y"}, int'(r1y), m_c1y);
    check_val({tag, "_c2x"}, int'(r2x), m_c2x);
    check_val({tag, "_c2y"}, int'(r2y), m_c2y);
    check_val({tag, "_cover"}, int'(res_cover), m_cover);
    check_val({tag, "_tmo"}, int'(res_timeout), m_timeout);
  endtask

  // Start a frame; optionally write an entry in the same cycle as start.
  task automatic do_start(input bit wr, input int a, input int px, input int py);
    start = 1'b1;
    wr_en = wr; wr_addr = 6'(a); wr_x = 4'(px); wr_y = 4'(py);
    if (wr && a < NPTS) begin mx[a] = px; my[a] = py; end
    tick();
    start = 1'b0; wr_en = 1'b0;
  endtask

  // Check all NPTS stream points while pushing ignored writes and DONEs.
  task automatic stream_check(input string tag);
    for (int k = 0; k < NPTS; k++) begin
      check_val({tag, "_sx"}, int'(x), mx[k]);
      check_val({tag, "_sy"}, int'(y), my[k]);
      wr_en = 1'($urandom_range(1, 0)); wr_addr = 6'd3;
      wr_x = 4'($urandom); wr_y = 4'($urandom);
      done = 1'($urandom_range(1, 0));
      tick();
    end
    wr_en = 1'b0; done = 1'b0;
    check_val({tag, "_wait_x"}, int'(x), 0);
    check_val({tag, "_wait_y"}, int'(y), 0);
    check_val({tag, "_wait_busy"}, int'(busy), 1);
  endtask

  // Wait some cycles (with an ignored start and writes), then pulse DONE.
  task automatic finish_done(input string tag, input int wcyc,
                             input int a1x, input int a1y, input int a2x, input int a2y);
    int n;
    for (int w = 0; w < wcyc; w++) begin
      start = (w == 1);
      wr_en = 1'($urandom_range(1, 0)); wr_addr = 6'($urandom_range(NPTS - 1, 0));
      wr_x = 4'($urandom); wr_y = 4'($urandom);
      tick();
    end
    start = 1'b0; wr_en = 1'b0;
    done = 1'b1; c1x = 4'(a1x); c1y = 4'(a1y); c2x = 4'(a2x); c2y = 4'(a2y);
    tick();
    done = 1'b0; c1x = 4'($urandom); c1y = 4'($urandom); c2x = 4'($urandom); c2y = 4'($urandom);
    n = 1;
    while (!res_valid && n < 200) begin tick(); n++; end
`ifdef LASER_FEED_SCORE_EN
    check_val({tag, "_lat"}, n, NPTS + 1);
    m_cover = model_cover(a1x, a1y, a2x, a2y);
`else
    check_val({tag, "_lat"}, n, 1);
    m_cover = 0;
`endif
    m_c1x = a1x; m_c1y = a1y; m_c2x = a2x; m_c2y = a2y; m_timeout = 0;
    check_results(tag);
    tick();
    check_val({tag, "_idle_busy"}, int'(busy), 0);
    check_val({tag, "_idle_valid"}, int'(res_valid), 0);
  endtask

  task automatic finish_timeout(input string tag);
    int n = 0;
    while (!res_valid && n < TIMEOUT + 100) begin
      start = (n == 5);
      tick();
      n++;
    end
    start = 1'b0;
    check_val({tag, "_lat"}, n, TIMEOUT + 1);
    m_timeout = 1; m_cover = 0;
    check_results(tag);
    tick();
    check_val({tag, "_idle_busy"}, int'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; start = 1'b0; done = 1'b0;
    wr_addr = 6'd0; wr_x = 4'd0; wr_y = 4'd0;
    c1x = 4'd0; c1y = 4'd0; c2x = 4'd0; c2y = 4'd0;
    tick(); tick();
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_x", int'(x), 0);
    check_val("rst_y", int'(y), 0);
    check_val("rst_valid", int'(res_valid), 0);
    check_results("rst");
    rst = 1'b0;
    tick();

    // Uniform (5,5) pattern, then DONE with C1=(5,5), C2=(12,12).
    for (int i = 0; i < NPTS; i++) load_pt(i, 5, 5);
    do_start(1'b0, 0, 0, 0);
    stream_check("t1");
    finish_done("t2", 3, 5, 5, 12, 12);

    // Half at (0,0), half at (15,15); entry 0 written in the start cycle.
    for (int i = 1; i < NPTS; i++) load_pt(i, (i < 20) ? 0 : 15, (i < 20) ? 0 : 15);
    load_pt(45, 9, 9);
    do_start(1'b1, 0, 0, 0);
    stream_check("t3");
    finish_done("t3", 2, 4, 0, 4, 0);

    // No DONE: timeout keeps previous centres.
    do_start(1'b0, 0, 0, 0);
    stream_check("t4");
    finish_timeout("t4");

    // Next start succeeds; start during WAIT launches no second frame.
    do_start(1'b0, 0, 0, 0);
    stream_check("t5");
    finish_done("t5", 4, 0, 0, 15, 15);
    for (int i = 0; i < 3; i++) begin
      check_val("t5_no_relaunch_busy", int'(busy), 0);
      check_val("t5_no_relaunch_x", int'(x), 0);
      tick();
    end

    // Reset at stream cycle 10, then replay the intact buffer.
    do_start(1'b0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      check_val("t6_sx", int'(x), mx[k]);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("t6_x", int'(x), 0);
    check_val("t6_y", int'(y), 0);
    check_val("t6_busy", int'(busy), 0);
    check_val("t6_valid", int'(res_valid), 0);
    m_c1x = 0; m_c1y = 0; m_c2x = 0; m_c2y = 0; m_cover = 0; m_timeout = 0;
    check_results("t6");
    tick();
    do_start(1'b0, 0, 0, 0);
    stream_check("t6r");
    finish_done("t6r", 1, 3, 2, 13, 14);

    // Randomized frames.
    for (int f = 0; f < 6; f++) begin
      int p1, p2;
      for (int i = 0; i < NPTS; i++) load_pt(i, $urandom_range(15, 0), $urandom_range(15, 0));
      load_pt($urandom_range(63, NPTS), $urandom_range(15, 0), $urandom_range(15, 0));
      p1 = $urandom_range(NPTS - 1, 0);
      p2 = $urandom_range(NPTS - 1, 0);
      do_start(1'b1, $urandom_range(3, 0), $urandom_range(15, 0), $urandom_range(15, 0));
      stream_check("rnd");
      finish_done("rnd", $urandom_range(10, 0), mx[p1], my[p1],
                  (f % 2 == 0) ? mx[p2] : $urandom_range(15, 0), my[p2]);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
